ulpi_tx_framer: RTL and testbench



---
 rtl/ulpi_defs.sv | 28 ++
 rtl/ulpi_tx_framer.sv | 146 ++++++++++++++
 tb/tb_ulpi_tx_framer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ulpi_defs.sv
// Shared ULPI link-side constants: TX CMD prefix, abort byte, framer state encodings
// and PID nibbles. Also holds the PID complement check used by the framer.
package ulpi_defs;

   localparam logic [3:0] TXCMD_PREFIX = 4'b0100;
   localparam logic [7:0] ABORT_BYTE   = 8'hFF;

   localparam logic [3:0] PID_ACK   = 4'h2;
   localparam logic [3:0] PID_NAK   = 4'hA;
   localparam logic [3:0] PID_STALL = 4'hE;
   localparam logic [3:0] PID_DATA0 = 4'h3;
   localparam logic [3:0] PID_DATA1 = 4'hB;

   typedef enum logic [5:0] {
      ST_IDLE  = 6'b000001,
      ST_TURN  = 6'b000010,
      ST_TXCMD = 6'b000100,
      ST_DATA  = 6'b001000,
      ST_STOP  = 6'b010000,
      ST_DRAIN = 6'b100000
   } state_t;

   // A well-formed PID byte carries the one's complement of the PID in its upper nibble.
   function automatic logic pid_ok(input logic [7:0] pid_byte);
      return (pid_byte[7:4] == ~pid_byte[3:0]);
   endfunction

endpackage

// File: rtl/ulpi_tx_framer.sv
// Converts encoder byte-stream packets into ULPI transmit sequences (TX CMD, data, stp).
// Optional PID complement check is enabled with `define ULPI_TX_PIDCHK_EN.
module ulpi_tx_framer
   import ulpi_defs::*;
#(
   parameter int unsigned TURN_CYCLES = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ulpi_dir_i,
   input  logic       ulpi_nxt_i,
   output logic [7:0] ulpi_data_o,
   output logic       ulpi_stp_o,
   input  logic       s_tvalid_i,
   output logic       s_tready_o,
   input  logic       s_tlast_i,
   input  logic [7:0] s_tdata_i,
   output logic       tx_busy_o,
   output logic       tx_done_o,
   output logic       tx_abort_o
);

   localparam logic [1:0] TURN_LOAD = 2'(TURN_CYCLES);

   state_t     state;
   state_t     state_next;
   logic [1:0] turn_cnt;
   logic       pid_bad;

`ifdef ULPI_TX_PIDCHK_EN
   assign pid_bad = s_tvalid_i && !pid_ok(s_tdata_i);
`else
   assign pid_bad = 1'b0;
`endif

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Turnaround counter: reloads while the PHY owns the bus, counts down once it lets go.
   always_ff @(posedge clock) begin
      if (reset) begin
         turn_cnt <= 2'd0;
      end else if (ulpi_dir_i) begin
         turn_cnt <= TURN_LOAD;
      end else if (turn_cnt != 2'd0) begin
         turn_cnt <= turn_cnt - 2'd1;
      end else begin
         turn_cnt <= turn_cnt;
      end
   end

   // Next-state and output decode; outputs are held at reset values while reset is high.
   always_comb begin
      state_next  = state;
      ulpi_data_o = 8'h00;
      ulpi_stp_o  = 1'b0;
      s_tready_o  = 1'b0;
      tx_busy_o   = 1'b0;
      tx_done_o   = 1'b0;
      tx_abort_o  = 1'b0;
      if (reset) begin
         state_next = ST_IDLE;
      end else begin
         tx_busy_o = (state != ST_IDLE);
         case (state)
            ST_IDLE: begin
               if (ulpi_dir_i) begin
                  state_next = ST_TURN;
               end else if (s_tvalid_i) begin
                  state_next = ST_TXCMD;
               end else begin
                  state_next = ST_IDLE;
               end
            end
            ST_TURN: begin
               // Exit on the dir-low cycle that brings the count to zero.
               if (ulpi_dir_i) begin
                  state_next = ST_TURN;
               end else if (turn_cnt <= 2'd1) begin
                  state_next = s_tvalid_i ? ST_TXCMD : ST_IDLE;
               end else begin
                  state_next = ST_TURN;
               end
            end
            ST_TXCMD: begin
               if (pid_bad) begin
                  s_tready_o = 1'b1;
                  tx_abort_o = 1'b1;
                  state_next = s_tlast_i ? ST_IDLE : ST_DRAIN;
               end else begin
                  ulpi_data_o = {TXCMD_PREFIX, s_tdata_i[3:0]};
                  if (ulpi_dir_i) begin
                     state_next = ST_TURN;
                  end else if (ulpi_nxt_i && s_tvalid_i) begin
                     s_tready_o = 1'b1;
                     state_next = s_tlast_i ? ST_STOP : ST_DATA;
                  end else begin
                     state_next = ST_TXCMD;
                  end
               end
            end
            ST_DATA: begin
               ulpi_data_o = s_tdata_i;
               if (ulpi_dir_i) begin
                  tx_abort_o = 1'b1;
                  state_next = ST_DRAIN;
               end else if (!s_tvalid_i) begin
                  // Underrun: stp with 0xFF makes the PHY emit a bit-stuff error.
                  ulpi_data_o = ABORT_BYTE;
                  ulpi_stp_o  = 1'b1;
                  tx_abort_o  = 1'b1;
                  state_next  = ST_DRAIN;
               end else if (ulpi_nxt_i) begin
                  s_tready_o = 1'b1;
                  state_next = s_tlast_i ? ST_STOP : ST_DATA;
               end else begin
                  state_next = ST_DATA;
               end
            end
            ST_STOP: begin
               ulpi_stp_o = 1'b1;
               tx_done_o  = 1'b1;
               state_next = ST_IDLE;
            end
            ST_DRAIN: begin
               s_tready_o = s_tvalid_i;
               if (s_tvalid_i && s_tlast_i) begin
                  state_next = ulpi_dir_i ? ST_TURN : ST_IDLE;
               end else begin
                  state_next = ST_DRAIN;
               end
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ulpi_tx_framer.sv
// Self-checking bench for ulpi_tx_framer: the bench plays both the upstream encoder and
// the PHY, and compares observed ULPI traffic against a packet-level reference model.
module tb_ulpi_tx_framer;

   localparam int TURN = 1;

   logic       clock;
   logic       reset;
   logic       ulpi_dir_i;
   logic       ulpi_nxt_i;
   logic [7:0] ulpi_data_o;
   logic       ulpi_stp_o;
   logic       s_tvalid_i;
   logic       s_tready_o;
   logic       s_tlast_i;
   logic [7:0] s_tdata_i;
   logic       tx_busy_o;
   logic       tx_done_o;
   logic       tx_abort_o;

   ulpi_tx_framer #(.TURN_CYCLES(TURN)) dut (
      .clock       (clock),
      .reset       (reset),
      .ulpi_dir_i  (ulpi_dir_i),
      .ulpi_nxt_i  (ulpi_nxt_i),
      .ulpi_data_o (ulpi_data_o),
      .ulpi_stp_o  (ulpi_stp_o),
      .s_tvalid_i  (s_tvalid_i),
      .s_tready_o  (s_tready_o),
      .s_tlast_i   (s_tlast_i),
      .s_tdata_i   (s_tdata_i),
      .tx_busy_o   (tx_busy_o),
      .tx_done_o   (tx_done_o),
      .tx_abort_o  (tx_abort_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   // upstream source
   logic [7:0] src[$];
   logic       src_last[$];
   int         idx;
   logic       src_en;

   // observations
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   int         acc_cyc[$];
   int         stp_cycs[$];
   int         stp_cnt, stp_ff, stp_zero, done_cnt, abort_cnt, cyc;
   logic [7:0] snap_data;
   logic       snap_stp, snap_tready, snap_busy, snap_done, snap_abort;

   task automatic start();
      got_q.delete(); acc_cyc.delete(); stp_cycs.delete();
      stp_cnt = 0; stp_ff = 0; stp_zero = 0; done_cnt = 0; abort_cnt = 0;
      idx = 0; src_en = 1'b1;
   endtask

   // reference: TX CMD from the PID nibble, then every later beat verbatim
   task automatic build_exp();
      exp_q.delete();
      for (int i = 0; i < src.size(); i++)
         exp_q.push_back(i == 0 ? (8'h40 | (src[0] & 8'h0F)) : src[i]);
   endtask

   function automatic logic [15:0] crc16(input logic [7:0] d0, input logic [7:0] d1);
      logic [15:0] c;
      logic [7:0]  b;
      c = 16'hFFFF;
      for (int k = 0; k < 2; k++) begin
         b = (k == 0) ? d0 : d1;
         for (int j = 0; j < 8; j++)
            c = (c[0] ^ b[j]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      return ~c;
   endfunction

   // one clock: drive after posedge, sample at negedge
   task automatic cycle(input logic nxt, input logic dir);
      logic v;
      v = src_en && (idx < src.size());
      ulpi_nxt_i = nxt;
      ulpi_dir_i = dir;
      s_tvalid_i = v;
      s_tdata_i  = v ? src[idx] : 8'h00;
      s_tlast_i  = v ? src_last[idx] : 1'b0;
      @(negedge clock);
      snap_data = ulpi_data_o; snap_stp = ulpi_stp_o; snap_tready = s_tready_o;
      snap_busy = tx_busy_o; snap_done = tx_done_o; snap_abort = tx_abort_o;
      if (nxt && !dir && v && s_tready_o) begin
         got_q.push_back(ulpi_data_o);
         acc_cyc.push_back(cyc);
      end
      if (ulpi_stp_o) begin
         stp_cnt++;
         stp_cycs.push_back(cyc);
         if (ulpi_data_o == 8'hFF) stp_ff++;
         if (ulpi_data_o == 8'h00) stp_zero++;
      end
      if (tx_done_o)  done_cnt++;
      if (tx_abort_o) abort_cnt++;
      if (v && s_tready_o) idx++;
      cyc++;
      @(posedge clock);
      #1;
   endtask

   task automatic run_auto(input int nxt_pct, input int budget);
      int  n;
      logic fin;
      n = 0; fin = 1'b0;
      while (!fin && n < budget) begin
         cycle(($urandom_range(99) < nxt_pct) ? 1'b1 : 1'b0, 1'b0);
         n++;
         if (idx >= src.size() && !snap_busy) fin = 1'b1;
      end
      n_cmp++;
      if (!fin) begin n_err++; $display("FAIL timeout: packet incomplete after %0d cycles (idx %0d of %0d)", n, idx, src.size()); end
   endtask

   task automatic drain_until_done(input string name, output int cycles);
      cycles = 0;
      while (idx < src.size() && cycles < 50) begin
         cycle(1'b0, 1'b0);
         if (!snap_tready) begin n_err++; n_cmp++; $display("FAIL %s_drain_tready: got %0b, expected 1", name, snap_tready); end
         cycles++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; src.delete(); src_last.delete(); start();
      cycle(1'b0, 1'b0); cycle(1'b1, 1'b0);
      reset = 1'b0;
      cycle(1'b1, 1'b0);
      n_cmp++; if (snap_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h, expected 00", snap_data); end
      n_cmp++; if (snap_stp !== 1'b0) begin n_err++; $display("FAIL reset_stp: got %b, expected 0", snap_stp); end
      n_cmp++; if (snap_tready !== 1'b0) begin n_err++; $display("FAIL reset_tready: got %b, expected 0", snap_tready); end
      n_cmp++; if ({snap_busy, snap_done, snap_abort} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b, expected 000", {snap_busy, snap_done, snap_abort}); end
   endtask

   task automatic test_ack();
      src = '{8'hD2}; src_last = '{1'b1}; start();
      run_auto(100, 20);
      n_cmp++; if (got_q.size() != 1 || got_q[0] !== 8'h42) begin n_err++; $display("FAIL ack_txcmd: got %0d bytes first %h, expected 1 byte 42", got_q.size(), got_q[0]); end
      n_cmp++; if (stp_cnt != 1 || stp_zero != 1) begin n_err++; $display("FAIL ack_stp: got %0d stp (%0d with 00), expected 1", stp_cnt, stp_zero); end
      n_cmp++; if (stp_cycs[0] != acc_cyc[0] + 1) begin n_err++; $display("FAIL ack_stp_timing: got cycle %0d, expected %0d", stp_cycs[0], acc_cyc[0] + 1); end
      n_cmp++; if (done_cnt != 1 || abort_cnt != 0) begin n_err++; $display("FAIL ack_flags: got done %0d abort %0d, expected 1 0", done_cnt, abort_cnt); end
   endtask

   task automatic test_data1_hold();
      logic [15:0] crc;
      crc = crc16(8'hA5, 8'h5A);
      src = '{8'h4B, 8'hA5, 8'h5A, crc[7:0], crc[15:8]};
      src_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      start(); build_exp();
      cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
         cycle(1'b0, 1'b0);
         n_cmp++; if (snap_data !== 8'h5A || snap_tready !== 1'b0) begin n_err++; $display("FAIL data1_hold: got data %h tready %b, expected 5A 0", snap_data, snap_tready); end
      end
      run_auto(100, 20);
      n_cmp++; if (got_q != exp_q) begin n_err++; $display("FAIL data1_bytes: got %0d bytes, expected %0d (4B A5 5A %h %h)", got_q.size(), exp_q.size(), crc[7:0], crc[15:8]); end
      n_cmp++; if (stp_zero != 1 || done_cnt != 1 || abort_cnt != 0) begin n_err++; $display("FAIL data1_end: got stp %0d done %0d abort %0d, expected 1 1 0", stp_zero, done_cnt, abort_cnt); end
   endtask

   task automatic test_random_packets();
      logic [3:0] pids[5];
      int len;
      logic [3:0] p;
      int bad;
      pids = '{4'h2, 4'hA, 4'hE, 4'h3, 4'hB};
      for (int pk = 0; pk < 16; pk++) begin
         p = pids[$urandom_range(4)];
         len = (p == 4'h3 || p == 4'hB) ? $urandom_range(3, 7) : 1;
         src.delete(); src_last.delete();
         src.push_back({~p, p}); src_last.push_back(len == 1);
         for (int i = 1; i < len; i++) begin
            src.push_back(8'($urandom)); src_last.push_back(i == len - 1);
         end
         start(); build_exp();
         run_auto($urandom_range(30, 100), 200);
         bad = (got_q.size() != exp_q.size()) ? 1 : 0;
         foreach (exp_q[i]) if (i < got_q.size() && got_q[i] !== exp_q[i]) bad = 1;
         n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rand_bytes pkt %0d: got %0d bytes first %h, expected %0d bytes first %h", pk, got_q.size(), got_q[0], exp_q.size(), exp_q[0]); end
         n_cmp++; if (stp_cnt != 1 || stp_zero != 1) begin n_err++; $display("FAIL rand_stp pkt %0d: got %0d stp, expected 1 with data 00", pk, stp_cnt); end
         n_cmp++; if (stp_cycs[0] != acc_cyc[acc_cyc.size() - 1] + 1) begin n_err++; $display("FAIL rand_stp_timing pkt %0d: got %0d, expected %0d", pk, stp_cycs[0], acc_cyc[acc_cyc.size() - 1] + 1); end
         n_cmp++; if (done_cnt != 1 || abort_cnt != 0) begin n_err++; $display("FAIL rand_flags pkt %0d: got done %0d abort %0d, expected 1 0", pk, done_cnt, abort_cnt); end
      end
   endtask

   task automatic test_dir_txcmd();
      src = '{8'hC3, 8'h11, 8'h22}; src_last = '{1'b0, 1'b0, 1'b1}; start();
      cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b1);
      n_cmp++; if (snap_tready !== 1'b0 || idx != 0) begin n_err++; $display("FAIL dir_txcmd_consume: got tready %b idx %0d, expected 0 0", snap_tready, idx); end
      cycle(1'b0, 1'b1);
      for (int k = 0; k < TURN; k++) begin
         cycle(1'b1, 1'b0);
         n_cmp++; if (snap_data !== 8'h00 || snap_busy !== 1'b1 || snap_tready !== 1'b0) begin n_err++; $display("FAIL dir_turn_idle: got data %h busy %b tready %b, expected 00 1 0", snap_data, snap_busy, snap_tready); end
      end
      cycle(1'b1, 1'b0);
      n_cmp++; if (snap_data !== 8'h43) begin n_err++; $display("FAIL dir_txcmd_retry: got %h, expected 43", snap_data); end
      run_auto(100, 20);
      n_cmp++; if (got_q.size() != 3 || got_q[0] !== 8'h43 || got_q[1] !== 8'h11 || got_q[2] !== 8'h22) begin n_err++; $display("FAIL dir_txcmd_bytes: got %0d bytes first %h, expected 43 11 22", got_q.size(), got_q[0]); end
      n_cmp++; if (done_cnt != 1 || abort_cnt != 0 || stp_zero != 1) begin n_err++; $display("FAIL dir_txcmd_end: got done %0d abort %0d stp %0d, expected 1 0 1", done_cnt, abort_cnt, stp_zero); end
   endtask

   task automatic test_dir_abort();
      int dc;
      src = '{8'h4B, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      src_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; start();
      cycle(1'b0, 1'b0);
      for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b1);
      n_cmp++; if (snap_abort !== 1'b1 || snap_tready !== 1'b0) begin n_err++; $display("FAIL abort_pulse: got abort %b tready %b, expected 1 0", snap_abort, snap_tready); end
      drain_until_done("abort", dc);
      n_cmp++; if (dc != 3) begin n_err++; $display("FAIL abort_drain_cycles: got %0d, expected 3", dc); end
      cycle(1'b0, 1'b0);
      n_cmp++; if (snap_busy !== 1'b0) begin n_err++; $display("FAIL abort_busy_clear: got %b, expected 0", snap_busy); end
      n_cmp++; if (got_q.size() != 3 || got_q[2] !== 8'h02) begin n_err++; $display("FAIL abort_bytes: got %0d bytes, expected 3 ending 02", got_q.size()); end
      n_cmp++; if (stp_cnt != 0 || done_cnt != 0 || abort_cnt != 1) begin n_err++; $display("FAIL abort_end: got stp %0d done %0d abort %0d, expected 0 0 1", stp_cnt, done_cnt, abort_cnt); end
   endtask

   task automatic test_underrun();
      int dc;
      src = '{8'hC3, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      src_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; start();
      cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      src_en = 1'b0;
      cycle(1'b1, 1'b0);
      n_cmp++; if (snap_stp !== 1'b1 || snap_data !== 8'hFF || snap_abort !== 1'b1) begin n_err++; $display("FAIL underrun_stp: got stp %b data %h abort %b, expected 1 FF 1", snap_stp, snap_data, snap_abort); end
      src_en = 1'b1;
      drain_until_done("underrun", dc);
      cycle(1'b0, 1'b0);
      n_cmp++; if (snap_busy !== 1'b0 || idx != 5) begin n_err++; $display("FAIL underrun_drain: got busy %b idx %0d, expected 0 5", snap_busy, idx); end
      n_cmp++; if (stp_cnt != 1 || stp_ff != 1 || abort_cnt != 1 || done_cnt != 0) begin n_err++; $display("FAIL underrun_counts: got stp %0d ff %0d abort %0d done %0d, expected 1 1 1 0", stp_cnt, stp_ff, abort_cnt, done_cnt); end
      n_cmp++; if (got_q.size() != 2 || got_q[1] !== 8'hAA) begin n_err++; $display("FAIL underrun_bytes: got %0d bytes, expected 43 AA", got_q.size()); end
   endtask

   task automatic test_reset_mid();
      src = '{8'h4B, 8'h01, 8'h02, 8'h03}; src_last = '{1'b0, 1'b0, 1'b0, 1'b1}; start();
      cycle(1'b0, 1'b0);
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      reset = 1'b1;
      cycle(1'b0, 1'b0);
      reset = 1'b0; src.delete(); src_last.delete(); idx = 0;
      cycle(1'b1, 1'b0);
      n_cmp++; if ({snap_data, snap_stp, snap_tready} !== 10'h000) begin n_err++; $display("FAIL rstmid_bus: got data %h stp %b tready %b, expected 00 0 0", snap_data, snap_stp, snap_tready); end
      n_cmp++; if ({snap_busy, snap_done, snap_abort} !== 3'b000) begin n_err++; $display("FAIL rstmid_flags: got %b, expected 000", {snap_busy, snap_done, snap_abort}); end
      n_cmp++; if (stp_cnt != 0) begin n_err++; $display("FAIL rstmid_no_stp: got %0d stp, expected 0", stp_cnt); end
   endtask

   task automatic test_back_to_back();
      src = '{8'hD2, 8'h5A}; src_last = '{1'b1, 1'b1}; start();
      run_auto(100, 30);
      n_cmp++; if (got_q.size() != 2 || got_q[0] !== 8'h42 || got_q[1] !== 8'h4A) begin n_err++; $display("FAIL b2b_bytes: got %0d bytes, expected 42 4A", got_q.size()); end
      n_cmp++; if (acc_cyc[1] != stp_cycs[0] + 2) begin n_err++; $display("FAIL b2b_gap: got second TX CMD at %0d, expected %0d", acc_cyc[1], stp_cycs[0] + 2); end
      n_cmp++; if (done_cnt != 2 || stp_zero != 2) begin n_err++; $display("FAIL b2b_done: got done %0d stp %0d, expected 2 2", done_cnt, stp_zero); end
   endtask

   task automatic test_pid_check();
      src = '{8'h22}; src_last = '{1'b1}; start();
`ifdef ULPI_TX_PIDCHK_EN
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      n_cmp++; if (snap_data !== 8'h00 || snap_tready !== 1'b1 || snap_abort !== 1'b1) begin n_err++; $display("FAIL pidchk_drop: got data %h tready %b abort %b, expected 00 1 1", snap_data, snap_tready, snap_abort); end
      cycle(1'b0, 1'b0);
      n_cmp++; if (snap_busy !== 1'b0 || idx != 1 || stp_cnt != 0) begin n_err++; $display("FAIL pidchk_end: got busy %b idx %0d stp %0d, expected 0 1 0", snap_busy, idx, stp_cnt); end
`else
      run_auto(100, 20);
      n_cmp++; if (got_q.size() != 1 || got_q[0] !== 8'h42 || abort_cnt != 0) begin n_err++; $display("FAIL pidchk_off: got %0d bytes first %h abort %0d, expected 42 0", got_q.size(), got_q[0], abort_cnt); end
`endif
   endtask

   initial begin
      cyc = 0; idx = 0; src_en = 1'b0;
      reset = 1'b1; ulpi_dir_i = 1'b0; ulpi_nxt_i = 1'b0;
      s_tvalid_i = 1'b0; s_tlast_i = 1'b0; s_tdata_i = 8'h00;
      @(posedge clock); #1;
      test_reset();
      test_ack();
      test_data1_hold();
      test_random_packets();
      test_dir_txcmd();
      test_dir_abort();
      test_underrun();
      test_reset_mid();
      test_back_to_back();
      test_pid_check();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
